// File: rtl/latch_sampler_pkg.sv
// rtl/latch_sampler_pkg.sv - shared state encodings for the latch sampler
// Purpose: FSM state type used by latch_sampler. 2'b11 is unused and
//          recovers to IDLE.
// Ports:   none (package)
package latch_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SETTLE  = 2'b01,
    PRESENT = 2'b10
  } state_t;

endpackage

// File: rtl/latch_sampler_sync_chain.sv
// rtl/latch_sampler_sync_chain.sv - multi-flop synchroniser for an asynchronous word
// Purpose: brings a level-sensitive asynchronous word into the clk domain.
// Ports:   clk   - system clock
//          reset - asynchronous, active-high reset (all stages to 0)
//          d     - asynchronous input word
//          q     - output of the last synchroniser stage
module sync_chain #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/latch_sampler.sv
// rtl/latch_sampler.sv - qualifies a latch Q word and presents it over valid/ready
// Purpose: synchronises D_in, waits for STABLE_CYCLES equal samples that differ
//          from the last qualified value, then presents that value once.
// Ports:   clk     - system clock
//          reset   - asynchronous, active-high reset
//          D_in    - latch Q output, asynchronous to clk
//          Q_out   - qualified value presented downstream
//          valid   - Q_out holds an unaccepted value
//          ready   - consumer accepts when valid && ready at a clk edge
//          overrun - sticky: input moved while a value was waiting
module latch_sampler
  import latch_sampler_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D_in,
  output logic [WIDTH-1:0] Q_out,
  output logic             valid,
  input  logic             ready,
  output logic             overrun
);

  localparam int             CNT_W    = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_prev;
  logic [WIDTH-1:0] held;
  logic [WIDTH-1:0] candidate;
  logic [CNT_W-1:0] cnt;
  state_t           state;

  sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (D_in),
    .q     (s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_prev    <= '0;
      held      <= '0;
      candidate <= '0;
      cnt       <= '0;
      Q_out     <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      state     <= IDLE;
    end else begin
      s_prev <= s;
      case (state)
        IDLE: begin
          if (s != held) begin
            candidate <= s;
            cnt       <= CNT_W'(1);
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          // Reverting to the baseline is treated as a glitch, not a new value.
          if (s == held) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (s != candidate) begin
            candidate <= s;
            cnt       <= CNT_W'(1);
          end else if (cnt == CNT_LAST) begin
            Q_out <= candidate;
            held  <= candidate;
            valid <= 1'b1;
            cnt   <= '0;
            state <= PRESENT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESENT: begin
          // Input is not tracked while presenting; IDLE re-compares s with
          // held afterwards so the final input value is still picked up.
          if (s != s_prev) overrun <= 1'b1;
          if (ready) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_sampler.sv
// tb/tb_latch_sampler.sv - scoreboard testbench for latch_sampler
module tb_latch_sampler;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] D_in;
  logic [7:0] Q_out;
  logic       valid;
  logic       ready;
  logic       overrun;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic valid_prev = 1'b0;
  exp_t sb [$];

  latch_sampler #(.WIDTH(8), .SYNC_STAGES(2), .STABLE_CYCLES(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .D_in    (D_in),
    .Q_out   (Q_out),
    .valid   (valid),
    .ready   (ready),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expect a presentation STABLE_CYCLES+SYNC_STAGES edges after this point.
  task automatic expect_val(input logic [7:0] v, input int lat);
    exp_t e;
    e.data = v;
    e.cyc  = cyc + lat;
    sb.push_back(e);
  endtask

  // Monitor: each new presentation (valid rising) is matched against the queue.
  always @(negedge clk) begin
    if (valid && !valid_prev) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got Q_out=%0h, expected no presentation (cycle %0d)", Q_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (Q_out !== e.data || cyc != e.cyc) begin
          fails++;
          $display("FAIL presentation: got Q_out=%0h at cycle %0d, expected %0h at cycle %0d",
                   Q_out, cyc, e.data, e.cyc);
        end
      end
    end
    valid_prev <= valid;
  end

  initial begin
    int p;
    reset = 1'b1;
    D_in  = 8'hA5;
    ready = 1'b1;

    // Reset with a nonzero input, then release.
    tick(3);
    check("rst_q_out", 32'(Q_out), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b0;
    expect_val(8'hA5, 5);
    tick(8);

    // Back to 00 (differs from held A5), then a clean 00->3C step.
    D_in = 8'h00;
    expect_val(8'h00, 5);
    tick(8);
    D_in = 8'h3C;
    expect_val(8'h3C, 5);
    tick(5);
    check("t2_valid_hi", 32'(valid), 32'h1);
    check("t2_q_out", 32'(Q_out), 32'h3C);
    tick(1);
    check("t2_valid_one_cycle", 32'(valid), 32'h0);
    tick(8);
    D_in = 8'h00;
    expect_val(8'h00, 5);
    tick(8);

    // Two-cycle glitch to FF must be filtered.
    D_in = 8'hFF;
    tick(2);
    D_in = 8'h00;
    tick(10);
    check("t3_q_out_kept", 32'(Q_out), 32'h00);

    // 11 for two cycles, then 22: only 22 presented.
    D_in = 8'h11;
    tick(2);
    D_in = 8'h22;
    expect_val(8'h22, 5);
    tick(10);
    check("t4_overrun_clear", 32'(overrun), 32'h0);

    // Stalled consumer, input moves while presenting.
    ready = 1'b0;
    D_in  = 8'h5A;
    expect_val(8'h5A, 5);
    tick(5);
    check("t5_valid_hi", 32'(valid), 32'h1);
    D_in = 8'h6B;
    tick(4);
    check("t5_q_frozen", 32'(Q_out), 32'h5A);
    check("t5_overrun", 32'(overrun), 32'h1);
    ready = 1'b1;
    p = cyc;
    expect_val(8'h6B, 4);
    tick(1);
    ready = 1'b0;
    check("t5_accept_edge", 32'(cyc), 32'(p + 1));
    check("t5_valid_dropped", 32'(valid), 32'h0);
    tick(3);
    check("t5_requal_valid", 32'(valid), 32'h1);
    check("t5_requal_q", 32'(Q_out), 32'h6B);
    check("t5_overrun_sticky", 32'(overrun), 32'h1);
    ready = 1'b1;
    tick(4);

    // Reset pulsed while SETTLE is in progress.
    D_in = 8'h77;
    tick(3);
    reset = 1'b1;
    #1;
    check("t6_rst_q_out", 32'(Q_out), 32'h00);
    check("t6_rst_valid", 32'(valid), 32'h0);
    check("t6_rst_overrun", 32'(overrun), 32'h0);
    tick(1);
    reset = 1'b0;
    expect_val(8'h77, 5);
    tick(10);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
